dsp_selftest_seq: RTL and testbench
===================================

// Module: dsp_selftest_seq
// PURPOSE
//  Parametrised DSP power-on/self-test sequencer. For N_VEC seeds it computes
//  r = v + v*v (v = s + s*K) twice: once on the hard-multiplier path and once on
//  a serial shift-add path. It compares the two results and, for vector 0 only,
//  also checks a known answer. Sits beside the DSP users; pass/err feed status LEDs.
// PARAMETERS
//  WIDTH    32   datapath width; all arithmetic is mod 2^WIDTH
//  SEED     127  seed of vector 0
//  STEP     3    seed increment per vector (s_i = SEED + i*STEP, mod 2^WIDTH)
//  K        5    first-stage multiplier constant
//  N_VEC    8    vectors per run (>=1)
//  KAT_EN   1    1: vector 0 fast result must also equal KAT_VAL
//  KAT_VAL  581406  known answer for vector 0 (127,K=5,W=32)
// PORTS
//  clk        in   1            system clock, rising edge
//  rst_n      in   1            async active-low reset
//  start      in   1            begin a run; sampled only in IDLE
//  inj_fault  in   1            sampled in F2: inverts bit 0 of fast result
//  busy       out  1            high from cycle after start until DONE entry
//  done       out  1            high in DONE; held until next accepted start
//  pass       out  1            valid when done: err_cnt==0 and KAT ok
//  err_cnt    out  $clog2(N_VEC+1)  count of vectors where fast!=slow
//  vec_idx    out  $clog2(N_VEC)|1  index of vector in progress / last vector
//  result     out  WIDTH        fast result of most recently compared vector
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, pass=0, err_cnt=0,
//   vec_idx=0, result=0; all internal regs 0. Reset mid-run aborts immediately.
//  FSM: IDLE -> LOAD -> F1 -> F2 -> S1 -> S2 -> CMP -> (LOAD | DONE); DONE -> LOAD.
//  IDLE/DONE: start=1 -> LOAD next cycle; clears err_cnt, vec_idx, kat_ok=1, done=0.
//  LOAD (1 cyc): s <= SEED + vec_idx*STEP (mod 2^W); slow accumulators cleared.
//  F1 (1 cyc): vf <= s + s*K (DSP multiply, truncated to WIDTH).
//  F2 (1 cyc): rf <= vf + vf*vf, bit 0 XOR inj_fault.
//  S1 (WIDTH cyc): shift-add s*K, bit i of K per cycle, LSB first; then
//   vs = s + acc.
//  S2 (WIDTH cyc): shift-add vs*vs, bit i of vs per cycle; then rs = vs + acc.
//   Only low WIDTH bits are kept in every partial sum.
//  CMP (1 cyc): result <= rf; if rf!=rs then err_cnt++ (saturates at N_VEC);
//   if vec_idx==0 && KAT_EN && rf!=KAT_VAL then kat_ok <= 0;
//   if vec_idx==N_VEC-1 go DONE, else vec_idx++ and go LOAD.
//  Per-vector latency: exactly 4 + 2*WIDTH cycles. Run = N_VEC*(4+2*WIDTH) cycles,
//   counted from the LOAD after start to DONE entry.
//  DONE: done=1, busy=0, pass = (err_cnt==0) && kat_ok. Outputs hold until start.
//  start while busy: ignored, with no effect on the current run.
//  Seed wrap: s_i computed mod 2^WIDTH; no overflow flags anywhere.
//  N_VEC=1: vec_idx stays 0; CMP goes straight to DONE.
// TESTING
//  T1 defaults, start pulse -> done after 8*68 cycles, pass=1, err_cnt=0,
//   result(vec0 at first CMP)=581406.
//  T2 inj_fault=1 for whole run -> err_cnt=8, pass=0; KAT fails (581407).
//  T3 inj_fault=1 only during vector 3's F2 -> err_cnt=1, pass=0.
//   KAT ok (vector 0 is not affected).
//  T4 start held high throughout -> exactly one run to DONE, then an immediate
//   re-run; busy never glitches mid-run.
//  T5 rst_n low at vector 2 S2 -> all outputs 0 same edge-independent instant;
//   fresh start gives T1 result.
//  T6 WIDTH=8, SEED=250, STEP=10, KAT_EN=0 -> seed wraps to 4 at vector 1.
//   Fast==slow for all vectors, pass=1.

Source files
------------

// File: rtl/dsp_selftest_seq.sv
// rtl/dsp_selftest_seq.sv - DSP self-test sequencer: hard-multiply vs serial shift-add cross-check
module dsp_selftest_seq #(
    parameter int WIDTH   = 32,
    parameter int SEED    = 127,
    parameter int STEP    = 3,
    parameter int K       = 5,
    parameter int N_VEC   = 8,
    parameter int KAT_EN  = 1,
    parameter int KAT_VAL = 581406,
    localparam int EW     = $clog2(N_VEC + 1),
    localparam int VW     = $clog2(N_VEC) | 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inj_fault,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [EW-1:0]    err_cnt,
    output logic [VW-1:0]    vec_idx,
    output logic [WIDTH-1:0] result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] SEED_W  = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] K_W     = WIDTH'(K);
    localparam logic [WIDTH-1:0] KAT_W   = WIDTH'(KAT_VAL);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [VW-1:0]    LAST_V  = VW'(N_VEC - 1);
    localparam logic [EW-1:0]    SAT     = EW'(N_VEC);

    typedef enum logic [2:0] {
        IDLE, LOAD, F1, F2, S1, S2, CMP, DONE
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] s, vf, rf, vs, rs, acc;
    logic [WIDTH-1:0] partial, acc_sum;
    logic             kat_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = LOAD;
            LOAD:       state_nx = F1;
            F1:         state_nx = F2;
            F2:         state_nx = S1;
            S1:         if (cnt == LAST) state_nx = S2;
            S2:         if (cnt == LAST) state_nx = CMP;
            CMP:        state_nx = (vec_idx == LAST_V) ? DONE : LOAD;
            default:    state_nx = IDLE;
        endcase
    end

    // One shared shift-add step: S1 walks the bits of K, S2 the bits of vs.
    always_comb begin
        partial = '0;
        if (state == S2) begin
            if (vs[cnt]) partial = vs << cnt;
        end else begin
            if (K_W[cnt]) partial = s << cnt;
        end
        acc_sum = acc + partial;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            s       <= '0;
            vf      <= '0;
            rf      <= '0;
            vs      <= '0;
            rs      <= '0;
            acc     <= '0;
            kat_ok  <= 1'b0;
            err_cnt <= '0;
            vec_idx <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_cnt <= '0;
                        vec_idx <= '0;
                        kat_ok  <= 1'b1;
                    end
                end
                LOAD: begin
                    s   <= SEED_W + WIDTH'(vec_idx) * STEP_W;
                    acc <= '0;
                    cnt <= '0;
                end
                F1: vf <= s + s * K_W;
                F2: rf <= (vf + vf * vf) ^ WIDTH'(inj_fault);
                S1, S2: begin
                    if (cnt == LAST) begin
                        if (state == S1) vs <= s + acc_sum;
                        else             rs <= vs + acc_sum;
                        acc <= '0;
                        cnt <= '0;
                    end else begin
                        acc <= acc_sum;
                        cnt <= cnt + CW'(1);
                    end
                end
                CMP: begin
                    result <= rf;
                    if (rf != rs && err_cnt != SAT) err_cnt <= err_cnt + EW'(1);
                    if (vec_idx == '0 && KAT_EN != 0 && rf != KAT_W) kat_ok <= 1'b0;
                    if (vec_idx != LAST_V) vec_idx <= vec_idx + VW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0) && kat_ok;

endmodule

// File: tb/tb_dsp_selftest_seq.sv
// tb/tb_dsp_selftest_seq.sv - self-checking bench for dsp_selftest_seq
module tb_dsp_selftest_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, inj_fault = 1'b0;
    logic        busy, done, pass;
    logic [3:0]  err_cnt;
    logic [2:0]  vec_idx;
    logic [31:0] result;

    logic        start8 = 1'b0, inj8 = 1'b0;
    logic        busy8, done8, pass8;
    logic [3:0]  err8;
    logic [2:0]  vec8;
    logic [7:0]  result8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dsp_selftest_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inj_fault(inj_fault),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .vec_idx(vec_idx), .result(result)
    );

    dsp_selftest_seq #(.WIDTH(8), .SEED(250), .STEP(10), .KAT_EN(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .inj_fault(inj8),
        .busy(busy8), .done(done8), .pass(pass8), .err_cnt(err8),
        .vec_idx(vec8), .result(result8)
    );

    function automatic logic [31:0] ref32(input int i);
        logic [31:0] sd, v;
        sd = 32'(127 + i * 3);
        v  = sd + sd * 32'd5;
        return v + v * v;
    endfunction

    function automatic logic [7:0] ref8(input int i);
        logic [7:0] sd, v;
        sd = 8'(250 + i * 10);
        v  = sd + sd * 8'd5;
        return v + v * v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  mask;
        logic [31:0] exp_r0;
        int          exp_err;
        logic        exp_pass;
    } vec_t;

    // Faults are injected in F2 of every vector whose mask bit is set.
    task automatic run32(input logic [7:0] mask, input logic [31:0] exp_r0);
        int bad = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 8 * 68; c++) begin
            inj_fault = mask[c / 68] && (c % 68 == 2);
            start     = (c == 100);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(posedge clk); #1;
            if (c % 68 == 67) begin
                chk("result", result, ref32(c / 68) ^ 32'(mask[c / 68]));
                if (c == 67) chk("kat_r0", result, exp_r0);
            end
        end
        inj_fault = 1'b0;
        start     = 1'b0;
        chk("busy_during_run", bad, 0);
        chk("done_at_latency", done, 1);
        chk("busy_at_done", busy, 0);
        chk("vec_idx_at_done", vec_idx, 7);
    endtask

    initial begin
        vec_t tbl[4];
        tbl[0] = '{8'h00, 32'd581406, 0, 1'b1};
        tbl[1] = '{8'hFF, 32'd581407, 8, 1'b0};
        tbl[2] = '{8'h08, 32'd581406, 1, 1'b0};
        tbl[3] = '{8'h01, 32'd581407, 1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_vec", vec_idx, 0);
        chk("rst_result", result, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run32(tbl[i].mask, tbl[i].exp_r0);
            chk("tbl_err_cnt", err_cnt, 64'(tbl[i].exp_err));
            chk("tbl_pass", pass, 64'(tbl[i].exp_pass));
        end

        for (int r = 0; r < 3; r++) begin
            logic [7:0] m;
            logic [31:0] r0;
            m  = 8'($urandom_range(0, 255));
            r0 = ref32(0) ^ 32'(m[0]);
            run32(m, r0);
            chk("rnd_err_cnt", err_cnt, 64'($countones(m)));
            chk("rnd_pass", pass, 64'((m == 8'h00) && (r0 == 32'd581406)));
        end

        begin
            int c = 0;
            int drops = 0;
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1;
            while (done !== 1'b1 && c < 700) begin
                if (busy !== 1'b1) drops++;
                @(posedge clk); #1;
                c++;
            end
            chk("t4_latency", c, 544);
            chk("t4_busy_glitch", drops, 0);
            chk("t4_pass", pass, 1);
            @(posedge clk); #1;
            chk("t4_rerun_busy", busy, 1);
            chk("t4_rerun_done", done, 0);
            start = 1'b0;
            rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
        end

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2 * 68 + 3 + 32 + 10) @(posedge clk);
        #1;
        chk("t5_busy_pre", busy, 1);
        chk("t5_vec_pre", vec_idx, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_pass", pass, 0);
        chk("t5_err", err_cnt, 0);
        chk("t5_vec", vec_idx, 0);
        chk("t5_result", result, 0);
        @(negedge clk) rst_n = 1'b1;
        run32(8'h00, 32'd581406);
        chk("t5_rerun_pass", pass, 1);
        chk("t5_rerun_err", err_cnt, 0);

        begin
            int bad = 0;
            @(posedge clk); #1 start8 = 1'b1;
            @(posedge clk); #1 start8 = 1'b0;
            for (int c = 0; c < 8 * 20; c++) begin
                if (busy8 !== 1'b1) bad++;
                @(posedge clk); #1;
                if (c % 20 == 19) chk("w8_result", result8, ref8(c / 20));
            end
            chk("w8_busy", bad, 0);
            chk("w8_done", done8, 1);
            chk("w8_err", err8, 0);
            chk("w8_pass", pass8, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
